// File: rtl/ctrl_encode_def.sv
// Shared encodings for the multi-cycle CPU control path: ALU, NPC, register
// destination and write-back selects, FSM state codes and instruction classes.
package ctrl_encode_def;

   // ALU operation codes; values above ALU_NOR are reserved
   localparam int ALU_W = 4;
   localparam logic [ALU_W-1:0] ALU_NOP  = 4'd0;
   localparam logic [ALU_W-1:0] ALU_ADD  = 4'd1;
   localparam logic [ALU_W-1:0] ALU_SUB  = 4'd2;
   localparam logic [ALU_W-1:0] ALU_AND  = 4'd3;
   localparam logic [ALU_W-1:0] ALU_OR   = 4'd4;
   localparam logic [ALU_W-1:0] ALU_SLT  = 4'd5;
   localparam logic [ALU_W-1:0] ALU_SLTU = 4'd6;
   localparam logic [ALU_W-1:0] ALU_SLL  = 4'd7;
   localparam logic [ALU_W-1:0] ALU_NOR  = 4'd8;

   // Next-PC selection
   localparam logic [1:0] NPC_PLUS4  = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;
   localparam logic [1:0] NPC_JR     = 2'b11;

   // ALU A-operand source
   localparam logic [1:0] ALUSRCA_RS    = 2'b00;
   localparam logic [1:0] ALUSRCA_SHAMT = 2'b01;
   localparam logic [1:0] ALUSRCA_LUI   = 2'b10;

   // Register-file destination select
   localparam logic [1:0] GPRSel_RD  = 2'b00;
   localparam logic [1:0] GPRSel_RT  = 2'b01;
   localparam logic [1:0] GPRSel_R31 = 2'b10;

   // Register-file write-data select
   localparam logic [1:0] WDSel_ALU = 2'b00;
   localparam logic [1:0] WDSel_MEM = 2'b01;
   localparam logic [1:0] WDSel_PC  = 2'b10;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type function codes
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   // FSM states
   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   // Instruction classes; each value is a bit index into the one-hot class vector
   typedef enum logic [3:0] {
      IC_RALU    = 4'd0,
      IC_IALU    = 4'd1,
      IC_LW      = 4'd2,
      IC_SW      = 4'd3,
      IC_BEQ     = 4'd4,
      IC_BNE     = 4'd5,
      IC_J       = 4'd6,
      IC_JAL     = 4'd7,
      IC_JR      = 4'd8,
      IC_ILLEGAL = 4'd9
   } iclass_t;

   localparam int IC_NUM = 10;

   // One-hot vector with only the given class bit set
   function automatic logic [IC_NUM-1:0] class_bit(input iclass_t c);
      logic [IC_NUM-1:0] v;
      v = '0;
      v[c] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mccpu_ctrl_decode.sv
// Combinational instruction decoder: classifies Op/Funct into a one-hot
// instruction class and produces the datapath selects for that instruction.
module mccpu_decode
   import ctrl_encode_def::*;
(
   input  logic [5:0]        Op,
   input  logic [5:0]        Funct,
   output logic [IC_NUM-1:0] iclass,
   output logic [ALU_W-1:0]  alu_op,
   output logic [1:0]        alu_src_a,
   output logic              alu_src_b,
   output logic              ext_op,
   output logic [1:0]        gpr_sel,
   output logic [1:0]        wd_sel
);

   // Decode opcode and function into class and selects; anything unknown is illegal
   always_comb begin
      iclass    = class_bit(IC_ILLEGAL);
      alu_op    = ALU_NOP;
      alu_src_a = ALUSRCA_RS;
      alu_src_b = 1'b0;
      ext_op    = 1'b0;
      gpr_sel   = GPRSel_RD;
      wd_sel    = WDSel_ALU;
      unique case (Op)
         OP_RTYPE: begin
            iclass = class_bit(IC_RALU);
            unique case (Funct)
               FN_ADD, FN_ADDU: alu_op = ALU_ADD;
               FN_SUB, FN_SUBU: alu_op = ALU_SUB;
               FN_AND:          alu_op = ALU_AND;
               FN_OR:           alu_op = ALU_OR;
               FN_NOR:          alu_op = ALU_NOR;
               FN_SLT:          alu_op = ALU_SLT;
               FN_SLTU:         alu_op = ALU_SLTU;
               FN_SLL: begin
                  alu_op    = ALU_SLL;
                  alu_src_a = ALUSRCA_SHAMT;
               end
               FN_JR:           iclass = class_bit(IC_JR);
               default:         iclass = class_bit(IC_ILLEGAL);
            endcase
         end
         OP_ADDI: begin
            iclass    = class_bit(IC_IALU);
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            ext_op    = 1'b1;
            gpr_sel   = GPRSel_RT;
         end
         OP_SLTI: begin
            iclass    = class_bit(IC_IALU);
            alu_op    = ALU_SLT;
            alu_src_b = 1'b1;
            ext_op    = 1'b1;
            gpr_sel   = GPRSel_RT;
         end
         OP_ORI: begin
            iclass    = class_bit(IC_IALU);
            alu_op    = ALU_OR;
            alu_src_b = 1'b1;
            gpr_sel   = GPRSel_RT;
         end
         OP_LUI: begin
            iclass    = class_bit(IC_IALU);
            alu_op    = ALU_NOP;
            alu_src_a = ALUSRCA_LUI;
            gpr_sel   = GPRSel_RT;
         end
         OP_LW: begin
            iclass    = class_bit(IC_LW);
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            ext_op    = 1'b1;
            gpr_sel   = GPRSel_RT;
            wd_sel    = WDSel_MEM;
         end
         OP_SW: begin
            iclass    = class_bit(IC_SW);
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            ext_op    = 1'b1;
         end
         OP_BEQ: begin
            iclass = class_bit(IC_BEQ);
            alu_op = ALU_SUB;
            ext_op = 1'b1;
         end
         OP_BNE: begin
            iclass = class_bit(IC_BNE);
            alu_op = ALU_SUB;
            ext_op = 1'b1;
         end
         OP_J:   iclass = class_bit(IC_J);
         OP_JAL: begin
            iclass  = class_bit(IC_JAL);
            gpr_sel = GPRSel_R31;
            wd_sel  = WDSel_PC;
         end
         default: iclass = class_bit(IC_ILLEGAL);
      endcase
   end

endmodule

// File: rtl/mccpu_ctrl.sv
// Multi-cycle CPU control unit: IF/ID/EX/MEM/WB sequencer with write-enable
// strobes, data-memory handshake with timeout, and sticky error flags.
module mccpu_ctrl
   import ctrl_encode_def::*;
#(
   parameter int ALUOP_W     = 4,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         Op,
   input  logic [5:0]         Funct,
   input  logic               Zero,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               EXTOp,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [1:0]         NPCOp,
   output logic [1:0]         ALUSrcA,
   output logic               ALUSrcB,
   output logic [1:0]         GPRSel,
   output logic [1:0]         WDSel,
   output logic               instr_done,
   output logic               illegal,
   output logic               mem_err,
   output logic [2:0]         state
);

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [IC_NUM-1:0] iclass;
   logic [ALU_W-1:0]  dec_alu_op;
   logic [1:0]        dec_alu_src_a;
   logic              dec_alu_src_b;
   logic              dec_ext_op;
   logic [1:0]        dec_gpr_sel;
   logic [1:0]        dec_wd_sel;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              illegal_q, mem_err_q;

   logic              pc_write, ir_write, reg_write, mem_read, mem_write;
   logic              done, set_illegal, set_mem_err, timeout_hit;
   logic [1:0]        npc_op;

   logic is_ralu, is_ialu, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr, is_ill;

   mccpu_decode u_decode (
      .Op        (Op),
      .Funct     (Funct),
      .iclass    (iclass),
      .alu_op    (dec_alu_op),
      .alu_src_a (dec_alu_src_a),
      .alu_src_b (dec_alu_src_b),
      .ext_op    (dec_ext_op),
      .gpr_sel   (dec_gpr_sel),
      .wd_sel    (dec_wd_sel)
   );

   assign is_ralu = iclass[IC_RALU];
   assign is_ialu = iclass[IC_IALU];
   assign is_lw   = iclass[IC_LW];
   assign is_sw   = iclass[IC_SW];
   assign is_beq  = iclass[IC_BEQ];
   assign is_bne  = iclass[IC_BNE];
   assign is_j    = iclass[IC_J];
   assign is_jal  = iclass[IC_JAL];
   assign is_jr   = iclass[IC_JR];
   assign is_ill  = iclass[IC_ILLEGAL];

   // Timeout fires on the last allowed MEM cycle when the memory still has not answered
   assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == TIMEOUT_LAST);

   // State register, MEM wait counter (zero outside MEM) and sticky flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IF;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= (state_q == S_MEM && state_d == S_MEM) ? cnt_q + CNT_W'(1) : '0;
         illegal_q <= illegal_q | set_illegal;
         mem_err_q <= mem_err_q | set_mem_err;
      end
   end

   // Next-state and per-state strobes; every retire pairs PCWrite with instr_done
   always_comb begin
      state_d     = state_q;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      npc_op      = NPC_PLUS4;
      done        = 1'b0;
      set_illegal = 1'b0;
      set_mem_err = 1'b0;
      unique case (state_q)
         S_IF: begin
            ir_write = 1'b1;
            state_d  = S_ID;
         end
         S_ID: begin
            if (is_j) begin
               pc_write = 1'b1;
               npc_op   = NPC_JUMP;
               done     = 1'b1;
               state_d  = S_IF;
            end else if (is_jr) begin
               pc_write = 1'b1;
               npc_op   = NPC_JR;
               done     = 1'b1;
               state_d  = S_IF;
            end else if (is_jal) begin
               state_d = S_WB;
            end else if (is_ill) begin
               set_illegal = 1'b1;
               pc_write    = 1'b1;
               done        = 1'b1;
               state_d     = S_IF;
            end else begin
               state_d = S_EX;
            end
         end
         S_EX: begin
            if (is_beq || is_bne) begin
               pc_write = 1'b1;
               npc_op   = ((is_beq && Zero) || (is_bne && !Zero)) ? NPC_BRANCH : NPC_PLUS4;
               done     = 1'b1;
               state_d  = S_IF;
            end else if (is_lw || is_sw) begin
               state_d = S_MEM;
            end else if (is_ralu || is_ialu) begin
               state_d = S_WB;
            end else begin
               state_d = S_IF;
            end
         end
         S_MEM: begin
            mem_read  = is_lw;
            mem_write = is_sw;
            if (mem_ready) begin
               if (is_lw) begin
                  state_d = S_WB;
               end else begin
                  pc_write = 1'b1;
                  done     = 1'b1;
                  state_d  = S_IF;
               end
            end else if (timeout_hit) begin
               set_mem_err = 1'b1;
               pc_write    = 1'b1;
               done        = 1'b1;
               state_d     = S_IF;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            npc_op    = is_jal ? NPC_JUMP : NPC_PLUS4;
            done      = 1'b1;
            state_d   = S_IF;
         end
         default: state_d = S_IF;
      endcase
   end

   // Every output is forced low while reset is held
   always_comb begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      EXTOp      = 1'b0;
      ALUOp      = '0;
      NPCOp      = NPC_PLUS4;
      ALUSrcA    = ALUSRCA_RS;
      ALUSrcB    = 1'b0;
      GPRSel     = GPRSel_RD;
      WDSel      = WDSel_ALU;
      instr_done = 1'b0;
      illegal    = 1'b0;
      mem_err    = 1'b0;
      state      = 3'd0;
      if (!rst) begin
         PCWrite    = pc_write;
         IRWrite    = ir_write;
         RegWrite   = reg_write;
         MemRead    = mem_read;
         MemWrite   = mem_write;
         EXTOp      = dec_ext_op;
         ALUOp      = ALUOP_W'(dec_alu_op);
         NPCOp      = npc_op;
         ALUSrcA    = dec_alu_src_a;
         ALUSrcB    = dec_alu_src_b;
         GPRSel     = dec_gpr_sel;
         WDSel      = dec_wd_sel;
         instr_done = done;
         illegal    = illegal_q | set_illegal;
         mem_err    = mem_err_q | set_mem_err;
         state      = state_q;
      end
   end

endmodule

// File: tb/tb_mccpu_ctrl.sv
// Directed, table-driven bench for the multi-cycle control unit.
module tb_mccpu_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] Op, Funct;
   logic       Zero, mem_ready;
   logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite, EXTOp;
   logic [3:0] ALUOp;
   logic [1:0] NPCOp, ALUSrcA, GPRSel, WDSel;
   logic       ALUSrcB, instr_done, illegal, mem_err;
   logic [2:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   mccpu_ctrl #(.ALUOP_W(4), .MEM_TIMEOUT(15), .CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .Op         (Op),
      .Funct      (Funct),
      .Zero       (Zero),
      .mem_ready  (mem_ready),
      .PCWrite    (PCWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .EXTOp      (EXTOp),
      .ALUOp      (ALUOp),
      .NPCOp      (NPCOp),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .GPRSel     (GPRSel),
      .WDSel      (WDSel),
      .instr_done (instr_done),
      .illegal    (illegal),
      .mem_err    (mem_err),
      .state      (state)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   // ready_at: 0 = mem_ready held high everywhere, -1 = never, n = high on n-th MEM cycle
   typedef struct {
      logic [5:0] op;
      logic [5:0] funct;
      logic       zero;
      int         ready_at;
      int         cycles;
      int         npc;
      int         regw;
      int         mrd;
      int         mwr;
      int         aluop;
      int         srca;
      int         ext;
      int         gpr;
      int         wd;
      int         dstate;
      int         merr;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs[NV];

   // Captured results of one instruction run
   int r_cycles, r_npc, r_regw, r_mrd, r_mwr, r_aluop, r_srca, r_ext, r_gpr, r_wd, r_state, r_merr;
   logic r_done;

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Runs one instruction from IF until instr_done (bounded), starting at a negedge in IF
   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                                input int ready_at);
      int mem_cyc;
      Op = op; Funct = funct; Zero = zero;
      r_cycles = 0; r_npc = 0; r_regw = 0; r_mrd = 0; r_mwr = 0; r_aluop = 0;
      r_srca = 0; r_ext = 0; r_gpr = 0; r_wd = 0; r_state = 0; r_merr = 0;
      r_done = 1'b0;
      mem_cyc = 0;
      while (!r_done && r_cycles < 64) begin
         if (ready_at == 0) begin
            mem_ready = 1'b1;
         end else if (state == 3'd3) begin
            mem_cyc++;
            mem_ready = (ready_at > 0) && (mem_cyc == ready_at);
         end else begin
            mem_ready = 1'b0;
         end
         #1;
         r_cycles++;
         r_regw += int'(RegWrite);
         r_mrd  += int'(MemRead);
         r_mwr  += int'(MemWrite);
         if (RegWrite) begin
            r_gpr = int'(GPRSel);
            r_wd  = int'(WDSel);
         end
         if (instr_done) begin
            r_done  = 1'b1;
            r_npc   = int'(NPCOp);
            r_aluop = int'(ALUOp);
            r_srca  = int'(ALUSrcA);
            r_ext   = int'(EXTOp);
            r_state = int'(state);
            r_merr  = int'(mem_err);
         end
         @(negedge clk);
      end
      mem_ready = 1'b0;
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int regw_seen;
      int ready_cnt;
      rst = 1'b1; Op = 6'h23; Funct = 6'h00; Zero = 1'b0; mem_ready = 1'b1;

      //             op     funct  z  rdy  cyc npc rw mr mw alu sa ex gpr wd st me
      vecs[0]  = '{6'h00, 6'h20, 0,  0,   4,  0, 1, 0, 0, 1,  0, 0, 0,  0, 4, 0};
      vecs[1]  = '{6'h00, 6'h22, 0,  0,   4,  0, 1, 0, 0, 2,  0, 0, 0,  0, 4, 0};
      vecs[2]  = '{6'h00, 6'h24, 0,  0,   4,  0, 1, 0, 0, 3,  0, 0, 0,  0, 4, 0};
      vecs[3]  = '{6'h00, 6'h25, 0,  0,   4,  0, 1, 0, 0, 4,  0, 0, 0,  0, 4, 0};
      vecs[4]  = '{6'h00, 6'h27, 0,  0,   4,  0, 1, 0, 0, 8,  0, 0, 0,  0, 4, 0};
      vecs[5]  = '{6'h00, 6'h2a, 0,  0,   4,  0, 1, 0, 0, 5,  0, 0, 0,  0, 4, 0};
      vecs[6]  = '{6'h00, 6'h2b, 0,  0,   4,  0, 1, 0, 0, 6,  0, 0, 0,  0, 4, 0};
      vecs[7]  = '{6'h00, 6'h00, 0,  0,   4,  0, 1, 0, 0, 7,  1, 0, 0,  0, 4, 0};
      vecs[8]  = '{6'h08, 6'h00, 0,  0,   4,  0, 1, 0, 0, 1,  0, 1, 1,  0, 4, 0};
      vecs[9]  = '{6'h0d, 6'h00, 0,  0,   4,  0, 1, 0, 0, 4,  0, 0, 1,  0, 4, 0};
      vecs[10] = '{6'h0a, 6'h00, 0,  0,   4,  0, 1, 0, 0, 5,  0, 1, 1,  0, 4, 0};
      vecs[11] = '{6'h0f, 6'h00, 0,  0,   4,  0, 1, 0, 0, 0,  2, 0, 1,  0, 4, 0};
      vecs[12] = '{6'h23, 6'h00, 0,  0,   5,  0, 1, 1, 0, 1,  0, 1, 1,  1, 4, 0};
      vecs[13] = '{6'h23, 6'h00, 0,  3,   7,  0, 1, 3, 0, 1,  0, 1, 1,  1, 4, 0};
      vecs[14] = '{6'h2b, 6'h00, 0,  0,   4,  0, 0, 0, 1, 1,  0, 1, 0,  0, 3, 0};
      vecs[15] = '{6'h04, 6'h00, 1,  0,   3,  1, 0, 0, 0, 2,  0, 1, 0,  0, 2, 0};
      vecs[16] = '{6'h04, 6'h00, 0,  0,   3,  0, 0, 0, 0, 2,  0, 1, 0,  0, 2, 0};
      vecs[17] = '{6'h05, 6'h00, 1,  0,   3,  0, 0, 0, 0, 2,  0, 1, 0,  0, 2, 0};
      vecs[18] = '{6'h05, 6'h00, 0,  0,   3,  1, 0, 0, 0, 2,  0, 1, 0,  0, 2, 0};
      vecs[19] = '{6'h02, 6'h00, 0,  0,   2,  2, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0};
      vecs[20] = '{6'h00, 6'h08, 0,  0,   2,  3, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0};
      vecs[21] = '{6'h03, 6'h00, 0,  0,   3,  2, 1, 0, 0, 0,  0, 0, 2,  2, 4, 0};
      vecs[22] = '{6'h3f, 6'h00, 0,  0,   2,  0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0};
      vecs[23] = '{6'h2b, 6'h00, 0, -1,  18,  0, 0, 0,15, 1,  0, 1, 0,  0, 3, 1};

      // Outputs are gated low while reset is held, even with a decodable Op
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_state",   int'(state), 0);
      checkOutput("rst_irwrite", int'(IRWrite), 0);
      checkOutput("rst_aluop",   int'(ALUOp), 0);
      checkOutput("rst_extop",   int'(EXTOp), 0);
      checkOutput("rst_wdsel",   int'(WDSel), 0);
      rst = 1'b0;
      mem_ready = 1'b0;
      #1;
      checkOutput("post_rst_state",   int'(state), 0);
      checkOutput("post_rst_irwrite", int'(IRWrite), 1);
      checkOutput("post_rst_illegal", int'(illegal), 0);
      checkOutput("post_rst_mem_err", int'(mem_err), 0);
      @(negedge clk);
      doReset();

      for (int i = 0; i < NV; i++) begin
         applyStimulus(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].ready_at);
         checkOutput($sformatf("v%0d_done", i),   int'(r_done), 1);
         checkOutput($sformatf("v%0d_cycles", i), r_cycles, vecs[i].cycles);
         checkOutput($sformatf("v%0d_npc", i),    r_npc,    vecs[i].npc);
         checkOutput($sformatf("v%0d_regw", i),   r_regw,   vecs[i].regw);
         checkOutput($sformatf("v%0d_memrd", i),  r_mrd,    vecs[i].mrd);
         checkOutput($sformatf("v%0d_memwr", i),  r_mwr,    vecs[i].mwr);
         checkOutput($sformatf("v%0d_aluop", i),  r_aluop,  vecs[i].aluop);
         checkOutput($sformatf("v%0d_srca", i),   r_srca,   vecs[i].srca);
         checkOutput($sformatf("v%0d_ext", i),    r_ext,    vecs[i].ext);
         checkOutput($sformatf("v%0d_gpr", i),    r_gpr,    vecs[i].gpr);
         checkOutput($sformatf("v%0d_wd", i),     r_wd,     vecs[i].wd);
         checkOutput($sformatf("v%0d_state", i),  r_state,  vecs[i].dstate);
         checkOutput($sformatf("v%0d_merr", i),   r_merr,   vecs[i].merr);
      end

      // Both sticky flags survive later instructions and clear only on reset
      applyStimulus(6'h00, 6'h20, 1'b0, 0);
      #1;
      checkOutput("sticky_illegal", int'(illegal), 1);
      checkOutput("sticky_mem_err", int'(mem_err), 1);
      doReset();
      #1;
      checkOutput("cleared_illegal", int'(illegal), 0);
      checkOutput("cleared_mem_err", int'(mem_err), 0);

      // Illegal opcode: flag visible in ID together with the PC+4 retire
      Op = 6'h3f; Funct = 6'h00;
      @(negedge clk);
      #1;
      checkOutput("ill_id_state",   int'(state), 1);
      checkOutput("ill_id_flag",    int'(illegal), 1);
      checkOutput("ill_id_pcwrite", int'(PCWrite), 1);
      checkOutput("ill_id_npc",     int'(NPCOp), 0);
      checkOutput("ill_id_done",    int'(instr_done), 1);
      @(negedge clk);
      checkOutput("ill_next_state", int'(state), 0);
      checkOutput("ill_next_flag",  int'(illegal), 1);

      // Timeout path cycle by cycle: mem_err rises only on the 15th MEM cycle
      doReset();
      Op = 6'h2b; Funct = 6'h00; mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      ready_cnt = 0;
      for (int k = 1; k <= 14; k++) begin
         ready_cnt += int'(mem_err) + int'(PCWrite);
         @(negedge clk);
      end
      checkOutput("to_early_err_or_pc", ready_cnt, 0);
      checkOutput("to_last_state",   int'(state), 3);
      checkOutput("to_last_memwr",   int'(MemWrite), 1);
      checkOutput("to_last_mem_err", int'(mem_err), 1);
      checkOutput("to_last_pcwrite", int'(PCWrite), 1);
      checkOutput("to_last_npc",     int'(NPCOp), 0);

      // Reset in MEM of a lw aborts it with no register write
      doReset();
      Op = 6'h23; Funct = 6'h00; mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("lwrst_in_mem",  int'(state), 3);
      checkOutput("lwrst_memread", int'(MemRead), 1);
      rst = 1'b1;
      #1;
      checkOutput("lwrst_gated_memread", int'(MemRead), 0);
      Op = 6'h02;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("lwrst_back_to_if", int'(state), 0);
      regw_seen = 0;
      for (int k = 0; k < 4; k++) begin
         regw_seen += int'(RegWrite);
         @(negedge clk);
      end
      checkOutput("lwrst_no_regwrite", regw_seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
